// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback requesters, arbiter and register-file write port bundle
interface rf_wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        wb_stall;
  logic        we;
  logic [4:0]  w_add;
  logic [31:0] w_data;
  logic        force_alu;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, wb_stall,
    input  alu_ready, mem_ready, we, w_add, w_data, force_alu
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, wb_stall,
    output alu_ready, mem_ready, we, w_add, w_data, force_alu
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between ALU and load writebacks
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);
  typedef enum logic {MEM_PRIO, FORCE_ALU} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             go, alu_gnt, mem_gnt;
  // grant decode: loads win unless the ALU has been starved long enough
  always_comb begin
    go            = !rst && !bus.wb_stall;
    alu_gnt       = go && bus.alu_valid && (!bus.mem_valid || state == FORCE_ALU);
    mem_gnt       = go && bus.mem_valid && !alu_gnt;
    bus.alu_ready = alu_gnt;
    bus.mem_ready = mem_gnt;
    bus.force_alu = state == FORCE_ALU;
  end
  // starvation count and priority state; forcing takes effect the cycle the limit is reached
  always_comb begin
    cnt_n   = (!bus.alu_valid || alu_gnt) ? '0 : (mem_gnt && cnt < LIMIT) ? cnt + 1'b1 : cnt;
    state_n = (state == MEM_PRIO) ? ((cnt_n == LIMIT) ? FORCE_ALU : MEM_PRIO)
                                  : ((alu_gnt || !bus.alu_valid) ? MEM_PRIO : FORCE_ALU);
  end
  // registered write port; x0 requests are accepted but never enable a write
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MEM_PRIO;
      cnt        <= '0;
      bus.we     <= 1'b0;
      bus.w_add  <= '0;
      bus.w_data <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bus.we <= (alu_gnt && |bus.alu_rd) || (mem_gnt && |bus.mem_rd);
      if (alu_gnt || mem_gnt) begin
        bus.w_add  <= alu_gnt ? bus.alu_rd : bus.mem_rd;
        bus.w_data <= alu_gnt ? bus.alu_data : bus.mem_data;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and randomized checks of the writeback arbiter
module tb_rf_wb_arbiter;
  localparam int LIMIT = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  rf_wb_arbiter_if bus ();
  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // reference: how many loads in a row have overtaken a waiting ALU request
  int          m_starve = 0;
  bit          m_we = 1'b0;
  logic [4:0]  m_add = '0;
  logic [31:0] m_data = '0;
  function automatic void m_pick(output bit ga, output bit gm);
    bit ok;
    ok = !rst && !bus.wb_stall;
    ga = ok && bus.alu_valid && (!bus.mem_valid || m_starve >= LIMIT);
    gm = ok && bus.mem_valid && !ga;
  endfunction
  always @(posedge clk) begin
    bit ga, gm;
    m_pick(ga, gm);
    if (rst) begin
      m_starve = 0;
      m_we     = 1'b0;
      m_add    = '0;
      m_data   = '0;
    end else begin
      m_we = (ga && bus.alu_rd != 0) || (gm && bus.mem_rd != 0);
      if (ga) begin m_add = bus.alu_rd; m_data = bus.alu_data; end
      else if (gm) begin m_add = bus.mem_rd; m_data = bus.mem_data; end
      if (!bus.alu_valid || ga) m_starve = 0;
      else if (gm && m_starve < LIMIT) m_starve++;
    end
  end
  task automatic test_reset();
    bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
    bus.mem_valid = 1; bus.mem_rd = 5'd2; bus.mem_data = 32'h2;
    bus.wb_stall = 0; rst = 1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready got %b want 0", bus.alu_ready); end
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready got %b want 0", bus.mem_ready); end
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.we); end
    checks++; if (bus.w_add !== 5'd0) begin errors++; $display("FAIL reset_w_add got %0d want 0", bus.w_add); end
    checks++; if (bus.w_data !== 32'h0) begin errors++; $display("FAIL reset_w_data got %h want 0", bus.w_data); end
    checks++; if (bus.force_alu !== 1'b0) begin errors++; $display("FAIL reset_force got %b want 0", bus.force_alu); end
    @(posedge clk) #1; rst = 0; bus.alu_valid = 0; bus.mem_valid = 0;
  endtask
  task automatic test_single_alu();
    @(posedge clk) #1; bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready got %b want 1", bus.alu_ready); end
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL single_mem_ready got %b want 0", bus.mem_ready); end
    @(posedge clk) #1; bus.alu_valid = 0;
    @(negedge clk);
    checks++; if (bus.we !== 1'b1) begin errors++; $display("FAIL single_we got %b want 1", bus.we); end
    checks++; if (bus.w_add !== 5'd5) begin errors++; $display("FAIL single_w_add got %0d want 5", bus.w_add); end
    checks++; if (bus.w_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_w_data got %h want deadbeef", bus.w_data); end
    @(negedge clk);
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL single_we_after got %b want 0", bus.we); end
  endtask
  task automatic test_conflict();
    @(posedge clk) #1;
    bus.mem_valid = 1; bus.mem_rd = 5'd3; bus.mem_data = 32'h11;
    bus.alu_valid = 1; bus.alu_rd = 5'd4; bus.alu_data = 32'h22;
    @(negedge clk);
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL conflict_mem_ready got %b want 1", bus.mem_ready); end
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL conflict_alu_wait got %b want 0", bus.alu_ready); end
    @(posedge clk) #1; bus.mem_valid = 0;
    @(negedge clk);
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL conflict_alu_ready got %b want 1", bus.alu_ready); end
    checks++; if ({bus.we, bus.w_add, bus.w_data} !== {1'b1, 5'd3, 32'h11}) begin errors++; $display("FAIL conflict_write1 got %b/%0d/%h want 1/3/11", bus.we, bus.w_add, bus.w_data); end
    @(posedge clk) #1; bus.alu_valid = 0;
    @(negedge clk);
    checks++; if ({bus.we, bus.w_add, bus.w_data} !== {1'b1, 5'd4, 32'h22}) begin errors++; $display("FAIL conflict_write2 got %b/%0d/%h want 1/4/22", bus.we, bus.w_add, bus.w_data); end
  endtask
  task automatic test_starvation();
    bit fa;
    @(posedge clk) #1;
    bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'hA7;
    bus.mem_valid = 1; bus.mem_rd = 5'd9; bus.mem_data = 32'h100;
    for (int k = 0; k < 5; k++) begin
      fa = (k == LIMIT);
      @(negedge clk);
      checks++; if (bus.alu_ready !== fa) begin errors++; $display("FAIL starve_alu_ready[%0d] got %b want %b", k, bus.alu_ready, fa); end
      checks++; if (bus.mem_ready !== !fa) begin errors++; $display("FAIL starve_mem_ready[%0d] got %b want %b", k, bus.mem_ready, !fa); end
      checks++; if (bus.force_alu !== fa) begin errors++; $display("FAIL starve_force[%0d] got %b want %b", k, bus.force_alu, fa); end
      if (k == 4) begin
        checks++; if ({bus.w_add, bus.w_data} !== {5'd7, 32'hA7}) begin errors++; $display("FAIL starve_alu_write got %0d/%h want 7/a7", bus.w_add, bus.w_data); end
      end
      @(posedge clk) #1;
      if (!fa) bus.mem_data = 32'h100 + 32'(k) + 1;
    end
    bus.alu_valid = 0; bus.mem_valid = 0;
    @(negedge clk);
    checks++; if ({bus.we, bus.w_add, bus.w_data} !== {1'b1, 5'd9, 32'h103}) begin errors++; $display("FAIL starve_mem_resume got %b/%0d/%h want 1/9/103", bus.we, bus.w_add, bus.w_data); end
  endtask
  task automatic test_x0_drop();
    @(posedge clk) #1; bus.mem_valid = 1; bus.mem_rd = 5'd0; bus.mem_data = 32'hFFFFFFFF;
    @(negedge clk);
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL x0_mem_ready got %b want 1", bus.mem_ready); end
    @(posedge clk) #1; bus.mem_valid = 0;
    @(negedge clk);
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL x0_we got %b want 0", bus.we); end
  endtask
  task automatic test_stall_and_reset();
    @(posedge clk) #1;
    bus.alu_valid = 1; bus.alu_rd = 5'd2; bus.alu_data = 32'h22;
    bus.mem_valid = 1; bus.mem_rd = 5'd6; bus.mem_data = 32'h66;
    @(negedge clk);
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL stall_pre_mem got %b want 1", bus.mem_ready); end
    @(posedge clk) #1; bus.wb_stall = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if ({bus.alu_ready, bus.mem_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d] got %b want 00", k, {bus.alu_ready, bus.mem_ready}); end
      if (k > 0) begin
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL stall_we[%0d] got %b want 0", k, bus.we); end
      end
      @(posedge clk) #1;
    end
    bus.wb_stall = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({bus.alu_ready, bus.mem_ready, bus.force_alu} !== ((k == 2) ? 3'b101 : 3'b010)) begin errors++; $display("FAIL stall_release[%0d] got %b want %b", k, {bus.alu_ready, bus.mem_ready, bus.force_alu}, (k == 2) ? 3'b101 : 3'b010); end
      @(posedge clk) #1;
    end
    rst = 1;
    @(negedge clk);
    checks++; if ({bus.alu_ready, bus.mem_ready} !== 2'b00) begin errors++; $display("FAIL rst_mid_ready got %b want 00", {bus.alu_ready, bus.mem_ready}); end
    @(posedge clk) #1; rst = 0;
    @(negedge clk);
    checks++; if ({bus.we, bus.force_alu, bus.mem_ready} !== 3'b001) begin errors++; $display("FAIL rst_mid_state got %b want 001", {bus.we, bus.force_alu, bus.mem_ready}); end
    @(posedge clk) #1; bus.alu_valid = 0; bus.mem_valid = 0;
  endtask
  task automatic test_random();
    bit ga, gm, a_pend, m_pend;
    a_pend = 0; m_pend = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk) #1;
      if (!a_pend) begin bus.alu_valid = $urandom_range(0, 3) != 0; bus.alu_rd = 5'($urandom); bus.alu_data = $urandom; end
      if (!m_pend) begin bus.mem_valid = $urandom_range(0, 3) != 0; bus.mem_rd = 5'($urandom); bus.mem_data = $urandom; end
      bus.wb_stall = $urandom_range(0, 7) == 0;
      rst = $urandom_range(0, 59) == 0;
      @(negedge clk);
      m_pick(ga, gm);
      checks++; if ({bus.alu_ready, bus.mem_ready} !== {ga, gm}) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", i, {bus.alu_ready, bus.mem_ready}, {ga, gm}); end
      checks++; if (bus.force_alu !== (m_starve >= LIMIT)) begin errors++; $display("FAIL rand_force[%0d] got %b want %b", i, bus.force_alu, m_starve >= LIMIT); end
      checks++; if ({bus.we, bus.w_add, bus.w_data} !== {m_we, m_add, m_data}) begin errors++; $display("FAIL rand_write[%0d] got %b/%0d/%h want %b/%0d/%h", i, bus.we, bus.w_add, bus.w_data, m_we, m_add, m_data); end
      a_pend = bus.alu_valid && !ga;
      m_pend = bus.mem_valid && !gm;
    end
    @(posedge clk) #1; rst = 0; bus.alu_valid = 0; bus.mem_valid = 0; bus.wb_stall = 0;
  endtask
  initial begin
    test_reset();
    test_single_alu();
    test_conflict();
    test_starvation();
    test_x0_drop();
    test_stall_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
